instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be asynchronous, active-low reset (rst=0 resets).
REQ-004 br_taken  input  1  SHALL be a redirect request from branch control.
REQ-005 br_target  input  32  SHALL be the redirect PC, valid when br_taken=1.
REQ-006 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-007 imem_addr  output  32  SHALL be the fetch address, valid while imem_req=1.
REQ-008 imem_gnt  input  1  SHALL be memory acceptance of the request.
REQ-009 imem_rvalid  input  1  SHALL be the response-valid strobe, one pulse per granted request.
REQ-010 imem_rdata  input  32  SHALL be the instruction word, valid with imem_rvalid.
REQ-011 if_valid  output  1  SHALL indicate that the buffer head holds an instruction for decode.
REQ-012 if_instr  output  32  SHALL be the buffer-head instruction.
REQ-013 if_pc  output  32  SHALL be the PC of the buffer-head instruction.
REQ-014 id_ready  input  1  SHALL be decode acceptance; pop occurs when if_valid & id_ready.

Function
REQ-015 State SHALL be PC (32b), FSM {REQ, WAIT}, drop flag, req_pc (32b), and a 2-entry FIFO of {pc, instr} with count 0..2.
REQ-016 REQ: imem_req SHALL be 1 iff (count + 0 outstanding) < 2 and br_taken=0; imem_addr SHALL equal PC.
REQ-017 REQ with imem_req & imem_gnt: req_pc<=PC, PC<=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-018 WAIT: imem_req SHALL be 0; at most one request SHALL be outstanding.
REQ-019 WAIT with imem_rvalid: if drop=0, push {req_pc, imem_rdata}; clear drop; go to REQ.
REQ-020 FIFO space SHALL be reserved at issue, so a push SHALL never occur at count=2.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 A pop at count=0 SHALL be impossible (if_valid=0); id_ready SHALL be ignored then.
REQ-023 if_valid SHALL be (count!=0); if_instr and if_pc SHALL show the head entry combinationally from registers.
REQ-024 br_taken=1 SHALL force PC<={br_target[31:2],2'b00} and flush the FIFO (count<=0), overriding any same-cycle push or pop.
REQ-025 br_taken in WAIT without imem_rvalid SHALL set drop=1; the later response SHALL be discarded.
REQ-026 br_taken in WAIT with imem_rvalid in the same cycle SHALL discard that data and go to REQ with drop=0.
REQ-027 br_taken in REQ SHALL suppress imem_req in that cycle; the request to the target SHALL be issued on the following cycle (redirect-to-request latency 1).
REQ-028 Back-to-back br_taken SHALL take the last target; each one SHALL re-flush.
REQ-029 Fetch latency: gnt in cycle N with rvalid in cycle M SHALL give if_valid=1 in cycle M+1 when the FIFO was empty.

Reset
REQ-030 rst=0 SHALL immediately set PC=RESET_PC, FSM=REQ, count=0, drop=0, req_pc=0, and FIFO contents to 0.
REQ-031 During reset, imem_req=0, if_valid=0, if_instr=0 and if_pc=0 SHALL hold.
REQ-032 On the first rising edge after rst deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; its late rvalid SHALL be ignored until the next grant.

Verification
REQ-034 Reset release, gnt=1, rvalid one cycle after gnt, id_ready=1 -> if_pc sequence 0,4,8,... with matching if_instr.
REQ-035 id_ready=0 held -> exactly 2 instructions buffered, imem_req stays 0, if_pc=0 retained; then id_ready=1 -> drains 0,4 in order.
REQ-036 br_taken with br_target=32'h0000_0103 during WAIT -> drop=1, pending response discarded, next imem_addr=32'h0000_0100, FIFO empty.
REQ-037 br_taken in the same cycle as rvalid -> data discarded, if_valid=0 next cycle, next imem_addr=target.
REQ-038 PC=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
REQ-039 rst pulsed low while in WAIT with count=1 -> all outputs 0 asynchronously; after release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: branch redirect, instruction-memory request/response
// and the fetch-to-decode handshake. The fetch unit is the master.
interface instr_fetch_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    input  br_taken,
    input  br_target,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    output br_taken,
    output br_target,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory request at a time, buffers up to
// two returned instructions for decode, and handles branch redirects by
// flushing the buffer and discarding any response already in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [0:0]  state;
  logic        drop;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic [31:0] br_pc;
  logic        issue;
  logic        push;
  logic        pop;

  // Redirect targets are word aligned by clearing the low two bits.
  assign br_pc = bus.br_target & 32'hFFFF_FFFC;

  // Space is reserved at issue: with no request outstanding in REQ, a
  // request may go out only if a buffer slot is still free. The request is
  // also held off while reset is asserted and in a redirect cycle.
  assign bus.imem_req  = rst && (state == ST_REQ) && (count < 2'd2) && !bus.br_taken;
  assign bus.imem_addr = pc;

  assign issue = bus.imem_req & bus.imem_gnt;
  assign push  = (state == ST_WAIT) && bus.imem_rvalid && !drop && !bus.br_taken;
  assign pop   = bus.if_valid & bus.id_ready;

  assign bus.if_valid = (count != 2'd0);
  assign bus.if_instr = fifo_instr[rd_ptr];
  assign bus.if_pc    = fifo_pc[rd_ptr];

  // Program counter: redirect wins over sequential advance; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      req_pc <= 32'h0000_0000;
    end else begin
      if (bus.br_taken) begin
        pc <= br_pc;
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
      if (issue) begin
        req_pc <= pc;
      end
    end
  end

  // Request/wait sequencing plus the flag that marks an in-flight response stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_REQ;
      drop  <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (issue) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          if (bus.imem_rvalid) begin
            state <= ST_REQ;
            drop  <= 1'b0;
          end else if (bus.br_taken) begin
            drop <= 1'b1;
          end
        end
      endcase
    end
  end

  // Two-entry instruction buffer; a redirect empties it regardless of push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'h0000_0000;
        fifo_instr[i] <= 32'h0000_0000;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (bus.br_taken) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_instr[wr_ptr] <= bus.imem_rdata;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed corner cases followed by
// randomized traffic, with decode deliveries checked against a program-order
// model of the instruction stream.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int delivered = 0;

  fetch_t      exp_q [$];
  fetch_t      mon_exp;
  logic [31:0] gen_pc;

  bit          auto_mode = 1'b0;
  int          gnt_pct   = 100;
  int          ready_pct = 100;
  int          br_pct    = 0;
  int          max_lat   = 0;
  bit          mem_busy  = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  int          mem_lat   = 0;

  // Contents of instruction memory: a simple hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  // Keep a window of upcoming program-order instructions ready for comparison.
  function void topUp();
    while (exp_q.size() < 8) begin
      exp_q.push_back(fetch_t'{gen_pc, mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  // Restart the expected stream at a new PC, forgetting anything undelivered.
  function void refill(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start;
    topUp();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic br, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.br_taken    = br;
    bus.br_target   = tgt;
    bus.id_ready    = rdy;
  endtask

  // One randomized cycle; decisions are taken after the monitor has updated
  // the memory model for the current cycle.
  task automatic autoCycle();
    logic        g, rv, br, rdy;
    logic [31:0] rd, tgt;
    @(negedge clk);
    #1;
    rv  = mem_busy && (mem_lat == 0);
    rd  = rv ? mem_word(mem_addr) : $urandom;
    g   = int'($urandom_range(99, 0)) < gnt_pct;
    rdy = int'($urandom_range(99, 0)) < ready_pct;
    br  = int'($urandom_range(99, 0)) < br_pct;
    tgt = $urandom;
    applyStimulus(g, rv, rd, br, tgt, rdy);
  endtask

  task automatic runRandom(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      autoCycle();
    end
  endtask

  // Monitor: scoreboard for decode deliveries, redirect/reset tracking, and
  // the memory responder's bookkeeping in randomized mode.
  always @(negedge clk) begin
    if (!rst) begin
      refill(RESET_PC);
      mem_busy = 1'b0;
    end else begin
      if (bus.if_valid && bus.id_ready) begin
        mon_exp = exp_q.pop_front();
        topUp();
        delivered++;
        checks++;
        if (bus.if_pc !== mon_exp.pc || bus.if_instr !== mon_exp.instr) begin
          errors++;
          $display("[TB] FAIL decode_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   bus.if_pc, bus.if_instr, mon_exp.pc, mon_exp.instr);
        end
      end
      if (bus.br_taken) begin
        refill({bus.br_target[31:2], 2'b00});
      end
      if (auto_mode) begin
        if (bus.imem_rvalid) begin
          mem_busy = 1'b0;
        end else if (mem_busy && mem_lat > 0) begin
          mem_lat--;
        end
        if (bus.imem_req) begin
          checks++;
          if (mem_busy) begin
            errors++;
            $display("[TB] FAIL one_outstanding: got imem_req=1 while busy, expected 0");
          end
          if (bus.imem_gnt) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_lat  = int'($urandom_range(32'(max_lat), 0));
          end
        end
      end
    end
  end

  int d0;

  initial begin
    rst             = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.br_taken    = 1'b0;
    bus.br_target   = 32'h0;
    bus.id_ready    = 1'b0;
    #1 rst = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("reset_imem_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("reset_if_valid", {31'b0, bus.if_valid}, 32'h0);
    checkOutput("reset_if_instr", bus.if_instr, 32'h0);
    checkOutput("reset_if_pc", bus.if_pc, 32'h0);
    @(posedge clk);

    $display("[TB] first fetch latency and buffering");
    applyStimulus(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release_imem_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("release_imem_addr", bus.imem_addr, RESET_PC);
    applyStimulus(0, 1, mem_word(32'h0), 0, 0, 0);
    @(negedge clk);
    checkOutput("wait_imem_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("wait_if_valid", {31'b0, bus.if_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("latency_if_valid", {31'b0, bus.if_valid}, 32'h1);
    checkOutput("latency_if_pc", bus.if_pc, 32'h0);
    checkOutput("latency_if_instr", bus.if_instr, mem_word(32'h0));
    checkOutput("next_imem_addr", bus.imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, mem_word(32'h4), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_imem_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("full_if_pc", bus.if_pc, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_hold_imem_req", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("drain_first_pc", bus.if_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("drain_second_pc", bus.if_pc, 32'h4);
    checkOutput("drain_imem_req", {31'b0, bus.imem_req}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("drained_if_valid", {31'b0, bus.if_valid}, 32'h0);
    checkOutput("fetch8_addr", bus.imem_addr, 32'h8);

    $display("[TB] redirects");
    applyStimulus(0, 0, 0, 1, 32'h0000_0103, 1);
    @(negedge clk);
    checkOutput("br_wait_imem_req", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(0, 1, mem_word(32'h8), 0, 0, 1);
    @(negedge clk);
    checkOutput("drop_wait_imem_req", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("drop_if_valid", {31'b0, bus.if_valid}, 32'h0);
    checkOutput("drop_imem_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("drop_imem_addr", bus.imem_addr, 32'h0000_0100);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, mem_word(32'h100), 1, 32'h0000_0200, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("br_rvalid_if_valid", {31'b0, bus.if_valid}, 32'h0);
    checkOutput("br_rvalid_imem_addr", bus.imem_addr, 32'h0000_0200);
    applyStimulus(1, 0, 0, 1, 32'h0000_0300, 1);
    @(negedge clk);
    checkOutput("br_req_suppressed", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("br_req_next_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("br_req_next_addr", bus.imem_addr, 32'h0000_0300);
    applyStimulus(0, 0, 0, 1, 32'h0000_0400, 1);
    applyStimulus(0, 0, 0, 1, 32'h0000_0502, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("br_last_wins_addr", bus.imem_addr, 32'h0000_0500);

    $display("[TB] address wrap and mid-transaction reset");
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_issue_addr", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, mem_word(32'hFFFF_FFFC), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_if_instr", bus.if_instr, mem_word(32'hFFFF_FFFC));
    checkOutput("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    bus.imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("async_rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    checkOutput("async_rst_if_instr", bus.if_instr, 32'h0);
    checkOutput("async_rst_if_pc", bus.if_pc, 32'h0);
    applyStimulus(0, 1, 32'hBAD0_BAD0, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rerelease_imem_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("rerelease_imem_addr", bus.imem_addr, RESET_PC);
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("late_rvalid_ignored", {31'b0, bus.if_valid}, 32'h0);

    $display("[TB] streaming with full grant and ready");
    auto_mode = 1'b1;
    gnt_pct = 100; ready_pct = 100; br_pct = 0; max_lat = 0;
    d0 = delivered;
    runRandom(1000);
    checkOutput("stream_throughput", {31'b0, (delivered - d0) >= 450}, 32'h1);

    $display("[TB] randomized traffic");
    d0 = delivered;
    gnt_pct = 60; ready_pct = 50; br_pct = 5; max_lat = 3;
    runRandom(1500);
    gnt_pct = 80; ready_pct = 30; br_pct = 10; max_lat = 2;
    runRandom(1500);
    checkOutput("random_progress", {31'b0, (delivered - d0) >= 200}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
